// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned DEFAULT_CLK_DIV = 434;
  localparam int unsigned FRAME_BITS      = 10;

endpackage

// File: rtl/baud_gen.sv
// Bit-period divider: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
module baud_gen #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr_i || (cnt_q == CntMax)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per valid/ready handshake, LSB first, registered line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

  tx_state_t         state_q;
  logic [DATA_W-1:0] sh_q;
  logic [IdxW-1:0]   idx_q;
  logic              tx_q;
  logic              busy_q;
  logic              ready_q;
  logic              tick;
  logic              baud_clr;

  // Counter parked at zero while idle, so every frame starts on a fresh bit period.
  assign baud_clr = (state_q == IDLE);

  baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud_gen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (baud_clr),
    .tick_o(tick)
  );

  // Line, busy and ready are loaded with the value of the state being entered,
  // so they change on the same edge as the state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            sh_q    <= data_i;
            idx_q   <= '0;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            idx_q   <= '0;
            tx_q    <= sh_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            sh_q <= sh_q >> 1;
            if (idx_q == LastIdx) begin
              state_q <= STOP;
              idx_q   <= '0;
              tx_q    <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
              tx_q  <= sh_q[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_o    = tx_q;
  assign busy_o  = busy_q;
  assign ready_o = ready_q;
  // Decoded from flops only: high during the final cycle of the stop bit.
  assign done_o  = (state_q == STOP) && tick;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-timeline model, vector table, corner sequences.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int D   = 4;
  localparam int D2  = 2;
  localparam int FL  = int'(FRAME_BITS) * D;
  localparam int FL2 = int'(FRAME_BITS) * D2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       tx, busy, done, ready;
  logic [7:0] data2 = 8'h00;
  logic       valid2 = 1'b0;
  logic       tx2, busy2, done2, ready2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  uart_tx #(.CLK_DIV(D), .DATA_W(8)) dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .data_i (data),
    .valid_i(valid),
    .ready_o(ready),
    .tx_o   (tx),
    .busy_o (busy),
    .done_o (done)
  );

  uart_tx #(.CLK_DIV(D2), .DATA_W(8)) dut2 (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .data_i (data2),
    .valid_i(valid2),
    .ready_o(ready2),
    .tx_o   (tx2),
    .busy_o (busy2),
    .done_o (done2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is ten bit slots of D cycles each, counted from the accept edge.
  int         pos = -1;
  logic [9:0] frm = 10'h3FF;
  int         acc_cnt = 0;
  int         frames_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos = -1;
    end else if (pos < 0) begin
      if (valid) begin
        pos = 0;
        frm = {1'b1, data, 1'b0};
        acc_cnt++;
      end
    end else begin
      pos++;
      if (pos == FL) begin
        pos = -1;
        frames_done++;
      end
    end
    #1;
    chk("m_tx",    tx,    (pos < 0) ? 1'b1 : frm[pos / D]);
    chk("m_busy",  busy,  pos >= 0);
    chk("m_ready", ready, pos < 0);
    chk("m_done",  done,  pos == FL - 1);
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // bit i = level of slot i (start, d0..d7, stop)
    bit         disturb;
  } vec_t;

  vec_t vecs[4];

  task automatic wait_accept(input int n0, output bit got);
    got = 1'b0;
    for (int w = 0; w < 50 && !got; w++) begin
      @(posedge clk);
      #2;
      got = (acc_cnt != n0);
    end
    chk("accept_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [9:0] line, input bit disturb);
    bit got;
    int n0, done_cnt, done_at;
    @(negedge clk);
    data  = d;
    valid = 1'b1;
    n0 = acc_cnt;
    wait_accept(n0, got);
    if (!got) begin
      valid = 1'b0;
      return;
    end
    done_cnt = 0;
    done_at  = -1;
    for (int j = 0; j <= FL; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #2;
      end
      if ((j % D == D / 2) && (j < FL))
        chk($sformatf("bit%0d_of_%02h", j / D, d), tx, line[j / D]);
      if (done === 1'b1) begin
        done_cnt++;
        done_at = j;
      end
      if (j == FL) begin
        chk($sformatf("end_tx_%02h", d), tx, 1'b1);
        chk($sformatf("end_busy_%02h", d), busy, 1'b0);
        chk($sformatf("end_ready_%02h", d), ready, 1'b1);
      end
      @(negedge clk);
      if (j == 0) valid = 1'b0;
      if (disturb && j == 10) begin
        data  = 8'hFF;
        valid = 1'b1;
      end
      if (disturb && j == 12) valid = 1'b0;
    end
    chk($sformatf("done_count_%02h", d), done_cnt, 1);
    chk($sformatf("done_pos_%02h", d), done_at, FL - 1);
    if (disturb) begin
      repeat (5) @(posedge clk);
      #2;
      chk("no_second_frame", busy, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit         got;
    int         n0, ndone, idle_cnt, busy_len, done2_at, rand_done, fd0;
    int         d_edge[2];
    logic [9:0] frame2;

    vecs[0] = '{data: 8'h55, line: 10'h2AA, disturb: 1'b0};
    vecs[1] = '{data: 8'hA3, line: 10'h346, disturb: 1'b0};
    vecs[2] = '{data: 8'h00, line: 10'h200, disturb: 1'b1};
    vecs[3] = '{data: 8'hFF, line: 10'h3FE, disturb: 1'b0};

    // Reset and idle behaviour
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      chk("idle_tx", tx, 1'b1);
      chk("idle_ready", ready, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
    end
    chk("idle2_tx", tx2, 1'b1);
    chk("idle2_ready", ready2, 1'b1);
    chk("idle2_busy", busy2, 1'b0);

    // Vector table
    for (int v = 0; v < 4; v++) send_frame(vecs[v].data, vecs[v].line, vecs[v].disturb);

    // Back-to-back with valid held high
    @(negedge clk);
    data  = 8'hA3;
    valid = 1'b1;
    n0 = acc_cnt;
    wait_accept(n0, got);
    ndone    = 0;
    idle_cnt = 0;
    d_edge[0] = -1;
    d_edge[1] = -1;
    for (int j = 0; j < 95; j++) begin
      @(posedge clk);
      #2;
      if (done === 1'b1) begin
        if (ndone < 2) d_edge[ndone] = cyc;
        ndone++;
      end else if (ndone == 1 && busy === 1'b0 && tx === 1'b1) begin
        idle_cnt++;
      end
      @(negedge clk);
      if (acc_cnt - n0 >= 2) valid = 1'b0;
    end
    chk("b2b_done_count", ndone, 2);
    chk("b2b_done_gap", d_edge[1] - d_edge[0], 41);
    chk("b2b_idle_cycles", idle_cnt, 1);

    // Reset during data bit 3 of 0x0F
    @(negedge clk);
    data  = 8'h0F;
    valid = 1'b1;
    n0 = acc_cnt;
    wait_accept(n0, got);
    @(negedge clk);
    valid = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    chk("pre_rst_busy", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (D * 12) begin
      @(posedge clk);
      #2;
      chk("post_rst_no_done", done, 1'b0);
    end
    send_frame(8'h81, 10'h302, 1'b0);

    // Minimum divider: 0xFF with CLK_DIV=2
    frame2 = {1'b1, 8'hFF, 1'b0};
    @(negedge clk);
    data2  = 8'hFF;
    valid2 = 1'b1;
    @(posedge clk);
    #2;
    busy_len = 0;
    done2_at = -1;
    for (int j = 0; j <= FL2; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #2;
      end
      if (j < FL2) chk($sformatf("d2_line_%0d", j), tx2, frame2[j / D2]);
      else begin
        chk("d2_end_tx", tx2, 1'b1);
        chk("d2_end_ready", ready2, 1'b1);
      end
      if (busy2 === 1'b1) busy_len++;
      if (done2 === 1'b1) done2_at = j;
      if (j == 0) begin
        @(negedge clk);
        valid2 = 1'b0;
      end
    end
    chk("d2_frame_len", busy_len, FL2);
    chk("d2_done_pos", done2_at, FL2 - 1);

    // Randomised traffic, including mid-frame data/valid activity
    repeat (10) @(posedge clk);
    fd0 = frames_done;
    rand_done = 0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      valid = ($urandom_range(0, 3) != 0);
      data  = 8'($urandom);
      @(posedge clk);
      #2;
      if (done === 1'b1) rand_done++;
    end
    @(negedge clk);
    valid = 1'b0;
    for (int c = 0; c < FL + 10; c++) begin
      @(posedge clk);
      #2;
      if (done === 1'b1) rand_done++;
    end
    chk("rand_done_count", rand_done, frames_done - fd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
